fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one circular synchronous FIFO write port among N_REQ producers. It sits directly in front of the FIFO and drives its `wr_en`/`data_in` from the selected producer, gated by the FIFO `full` flag. A burst lock lets one producer write up to BURST_MAX back-to-back words before the grant rotates, so short streams stay contiguous without starving the other producers.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bus and FIFO write port of the round-robin write arbiter.
// master = the arbiter, slave = the producers and FIFO around it.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 4
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    grant;
    logic                fifo_full;
    logic                fifo_wr_en;
    logic [DW-1:0]       fifo_data_in;
    logic [IW-1:0]       owner;
    logic                busy;

    modport master (
        input  req, req_data, fifo_full,
        output grant, fifo_wr_en, fifo_data_in, owner, busy
    );

    modport slave (
        output req, req_data, fifo_full,
        input  grant, fifo_wr_en, fifo_data_in, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with burst lock in front of one FIFO write port.
// Grants are combinational (zero latency); ownership state updates on the rising edge.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 4,
    parameter int BURST_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   own, own_n;
    logic [CW-1:0]   cnt, cnt_n;

    logic            gnt_valid;
    logic            gnt_new;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   own_inc;
    logic [IW-1:0]   search_start;

    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    assign own_inc      = inc_mod(own);
    assign search_start = (state == BURST) ? own_inc : ptr;

    // An owner still requesting keeps the port; otherwise the first requester from
    // search_start wins, which gives a same-cycle handover when the owner drops.
    always_comb begin : arbitrate
        logic [IW-1:0] idx;
        // NOTE: combinational blocks use blocking '=' and give every output a default
        // first, so no latch is inferred; clocked blocks use '<=' only.
        gnt_valid = 1'b0;
        gnt_new   = 1'b0;
        gnt_idx   = '0;
        idx       = search_start;
        if (rst && !bus.fifo_full) begin
            if (state == BURST && bus.req[own]) begin
                gnt_valid = 1'b1;
                gnt_idx   = own;
            end else begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (!gnt_valid && bus.req[idx]) begin
                        gnt_valid = 1'b1;
                        gnt_new   = 1'b1;
                        gnt_idx   = idx;
                    end
                    idx = inc_mod(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            own   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            own   <= own_n;
            cnt   <= cnt_n;
        end
    end

    // A full FIFO suppresses the grant and skips the release branch, freezing everything.
    always_comb begin : next_state
        state_n = state;
        ptr_n   = ptr;
        own_n   = own;
        cnt_n   = cnt;
        if (gnt_valid) begin
            if (gnt_new) begin
                own_n   = gnt_idx;
                cnt_n   = CW'(1);
                state_n = BURST;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            if (cnt_n == CW'(BURST_MAX)) begin
                state_n = IDLE;
                ptr_n   = inc_mod(own_n);
                cnt_n   = '0;
            end
        end else if (state == BURST && !bus.req[own] && !bus.fifo_full) begin
            state_n = IDLE;
            ptr_n   = own_inc;
            cnt_n   = '0;
        end
    end

    always_comb begin : outputs
        logic in_burst;
        in_burst         = rst && (state == BURST);
        bus.grant        = '0;
        bus.fifo_data_in = '0;
        if (gnt_valid) begin
            bus.grant[gnt_idx] = 1'b1;
            bus.fifo_data_in   = bus.req_data[gnt_idx*DW +: DW];
        end
        bus.fifo_wr_en = gnt_valid;
        bus.busy       = in_burst;
        bus.owner      = in_burst ? own : '0;
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboarded bench for fifo_wr_arbiter: directed scenarios then random traffic,
// each cycle's expectation comes from a queue-free round-robin reference model.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int BM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

    fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .BURST_MAX(BM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0]  grant;
        logic [DW-1:0] data;
        logic [1:0]    owner;
        logic          busy;
        logic          full;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Producer-side state driven onto the bus each cycle.
    logic [N-1:0]  req_v;
    logic [DW-1:0] dat[N];
    int            last_g;

    // Reference model: the arbitration rules stated in plain integer arithmetic.
    bit m_burst;
    int m_ptr, m_own, m_cnt;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step(input logic r, input logic full);
        int   g;
        int   start;
        exp_t e;
        rst           = r;
        bus.fifo_full = full;
        bus.req       = req_v;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = dat[i];

        g = -1;
        if (r && !full) begin
            if (m_burst && req_v[m_own]) g = m_own;
            else begin
                start = m_burst ? (m_own + 1) % N : m_ptr;
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_v[(start + k) % N]) g = (start + k) % N;
            end
        end
        e.grant = (g >= 0) ? N'(1 << g) : '0;
        e.data  = (g >= 0) ? dat[g] : '0;
        e.busy  = r && m_burst;
        e.owner = e.busy ? 2'(m_own) : 2'd0;
        e.full  = full;
        exp_q.push_back(e);
        last_g = g;

        if (!r) begin
            m_burst = 0; m_ptr = 0; m_own = 0; m_cnt = 0;
        end else if (g >= 0) begin
            if (m_burst && g == m_own) m_cnt++;
            else begin m_own = g; m_cnt = 1; m_burst = 1; end
            if (m_cnt == BM) begin m_burst = 0; m_ptr = (m_own + 1) % N; m_cnt = 0; end
        end else if (m_burst && !full) begin
            m_burst = 0; m_ptr = (m_own + 1) % N; m_cnt = 0;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [N-1:0] r);
        req_v = r;
    endtask

    // Monitor: outputs are sampled on the falling edge, half a cycle after inputs settle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant", bus.grant, e.grant);
            check("fifo_wr_en", bus.fifo_wr_en, |e.grant);
            check("fifo_data_in", bus.fifo_data_in, e.data);
            check("owner", bus.owner, e.owner);
            check("busy", bus.busy, e.busy);
            if (e.full) check("no_write_when_full", bus.fifo_wr_en, 1'b0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.fifo_full = 1'b0;
        bus.req       = '0;
        bus.req_data  = '0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        req_v = '0;
        m_burst = 0; m_ptr = 0; m_own = 0; m_cnt = 0;
        @(posedge clk);
        #1;

        // Reset with all requesting, then producer 0 wins first.
        set_req(4'b1111);
        step(0, 0); step(0, 0);
        step(1, 0);

        // Burst lock: 4,4,4,4 then 7,7,7,7 then 4.
        step(0, 0);
        dat[0] = 4'd4; dat[1] = 4'd7; set_req(4'b0011);
        repeat (9) step(1, 0);

        // Early release with same-cycle handover, then wrap-around from ptr=3.
        step(0, 0);
        dat[2] = 4'd9; dat[3] = 4'd12; dat[0] = 4'd1;
        set_req(4'b0100); step(1, 0); step(1, 0);
        set_req(4'b1000); step(1, 0);
        set_req(4'b0000); step(1, 0);
        set_req(4'b0100); step(1, 0);
        set_req(4'b0000); step(1, 0);
        set_req(4'b0101); step(1, 0);
        set_req(4'b0100); step(1, 0); step(1, 0);

        // Full stall mid-burst at cnt=2, resume with two more grants before rotation.
        step(0, 0);
        dat[0] = 4'd5; dat[1] = 4'd10;
        set_req(4'b0001); step(1, 0); step(1, 0);
        repeat (3) step(1, 1);
        set_req(4'b0011); repeat (3) step(1, 0);

        // Reset mid-burst: no write in the reset cycle, search restarts at 0.
        step(0, 0);
        set_req(4'b0001); step(1, 0); step(1, 0);
        step(0, 0);
        set_req(4'b0011); step(1, 0);

        // Random traffic obeying the hold-until-granted protocol.
        last_g = -1;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_v[i] && last_g == i) begin
                    req_v[i] = ($urandom_range(1) == 0);
                    dat[i]   = DW'($urandom);
                end else if (!req_v[i] && $urandom_range(9) < 4) begin
                    req_v[i] = 1'b1;
                    dat[i]   = DW'($urandom);
                end
            end
            step($urandom_range(99) != 0, $urandom_range(4) == 0);
        end

        set_req('0);
        step(1, 0);
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
